// File: rtl/kernel_top_join2_align.sv
// Two-stream join: each stream lands in its own FWFT FIFO and a pair is emitted when both heads are valid.
// Optional KERNEL_JOIN_SKEW_MON_EN adds max_skew, the peak |count1-count2| since reset.

module kernel_top_join2_align_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [W-1:0]    din,
    input  logic            pop,
    output logic [W-1:0]    dout,
    output logic [CNTW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

module kernel_top_join2_align #(
    parameter int STREAMW = 32,
    parameter int DEPTH   = 4,
    parameter int CNTW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid_in1,
    output logic               iready_in1,
    input  logic [STREAMW-1:0] in1,
    input  logic               ivalid_in2,
    output logic               iready_in2,
    input  logic [STREAMW-1:0] in2,
    output logic               ovalid,
    input  logic               oready,
    output logic [STREAMW-1:0] out1,
    output logic [STREAMW-1:0] out2,
    output logic [CNTW-1:0]    count1,
    output logic [CNTW-1:0]    count2
`ifdef KERNEL_JOIN_SKEW_MON_EN
    ,
    output logic [CNTW-1:0]    max_skew
`endif
);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [1:0]                 vld;
    logic [1:0]                 rdy;
    logic [1:0]                 push;
    logic [1:0][STREAMW-1:0]    din;
    logic [1:0][STREAMW-1:0]    head;
    logic [1:0][CNTW-1:0]       cnt;
    logic                       rdy_en;
    logic                       pop;

    // Holds iready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_en <= 1'b0;
        else      rdy_en <= 1'b1;
    end

    assign vld = {ivalid_in2, ivalid_in1};
    assign din = {in2, in1};
    assign pop = ovalid & oready;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        // Full blocks the push even when a pop lands the same cycle, keeping oready off this path.
        assign rdy[g]  = rdy_en & (cnt[g] != FULL);
        assign push[g] = vld[g] & rdy[g];

        kernel_top_join2_align_fifo #(
            .W     (STREAMW),
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .din   (din[g]),
            .pop   (pop),
            .dout  (head[g]),
            .count (cnt[g])
        );
    end

    assign iready_in1 = rdy[0];
    assign iready_in2 = rdy[1];
    assign count1     = cnt[0];
    assign count2     = cnt[1];
    assign ovalid     = (cnt[0] != '0) & (cnt[1] != '0);
    assign out1       = ovalid ? head[0] : '0;
    assign out2       = ovalid ? head[1] : '0;

`ifdef KERNEL_JOIN_SKEW_MON_EN
    logic [CNTW-1:0] skew;
    logic [CNTW-1:0] skew_sat;

    assign skew     = (cnt[0] >= cnt[1]) ? cnt[0] - cnt[1] : cnt[1] - cnt[0];
    assign skew_sat = (skew > FULL) ? FULL : skew;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  max_skew <= '0;
        else if (skew_sat > max_skew) max_skew <= skew_sat;
    end
`endif
endmodule
